// File: rtl/hud_draw_pkg.sv
// hud_draw_pkg: shared types and constants for the HUD sprite generator.
//  - Shared draw macros: `COL_BLACK, `COL_RED, `COL_GREEN, and `HUDDRAW
//    (the draw_fsm window for this source: 12 pip pixels + BAR_W*BAR_H bar
//    pixels + 3 cycles of latch/done/return overhead = 215 with defaults).
//  - hud_state_e: the hud_draw FSM state encoding.
//  - Default geometry parameters and a bar-length clamp helper.
`ifndef HUD_DRAW_MACROS
`define HUD_DRAW_MACROS
`define COL_BLACK 3'b000
`define COL_RED   3'b100
`define COL_GREEN 3'b010
`define HUDDRAW   (12 + 100 * 2 + 3)
`endif

package hud_draw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_PIPS  = 3'd2,
    ST_BAR   = 3'd3,
    ST_DONE  = 3'd4
  } hud_state_e;

  localparam int DEF_PIP_X0       = 150;
  localparam int DEF_PIP_Y0       = 0;
  localparam int DEF_BAR_X0       = 0;
  localparam int DEF_BAR_Y0       = 0;
  localparam int DEF_BAR_W        = 100;
  localparam int DEF_BAR_H        = 2;
  localparam int DEF_BLINK_PERIOD = 8;

  localparam logic [2:0] COL_BLACK = `COL_BLACK;
  localparam logic [2:0] COL_RED   = `COL_RED;
  localparam logic [2:0] COL_GREEN = `COL_GREEN;

  // Displayed bar length: health saturates at the bar width.
  function automatic logic [9:0] clamp_len(input logic [9:0] health,
                                           input logic [9:0] bar_w);
    clamp_len = (health > bar_w) ? bar_w : health;
  endfunction

endpackage

// File: rtl/hud_scan.sv
// hud_scan: x/y raster counter of W columns by H rows, row-major.
//  clk, resetn : clock, synchronous active-low reset
//  clear       : force position back to (0,0) (wins over step)
//  step        : advance one position, wrapping to (0,0) after the last
//  dx, dy      : current column / row
//  last        : current position is (W-1, H-1)
module hud_scan #(
  parameter int W  = 4,
  parameter int H  = 3,
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear,
  input  logic          step,
  output logic [CW-1:0] dx,
  output logic [CW-1:0] dy,
  output logic          last
);

  if (W < 1 || H < 1 || W > (1 << CW) || H > (1 << CW)) begin : g_size_err
    $error("hud_scan: W/H out of range for counter width");
  end

  localparam logic [CW-1:0] X_MAX = CW'(W - 1);
  localparam logic [CW-1:0] Y_MAX = CW'(H - 1);

  logic [CW-1:0] dx_q, dx_d;
  logic [CW-1:0] dy_q, dy_d;

  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (clear) begin
      dx_d = '0;
      dy_d = '0;
    end else if (step) begin
      if (dx_q == X_MAX) begin
        dx_d = '0;
        dy_d = (dy_q == Y_MAX) ? '0 : dy_q + 1'b1;
      end else begin
        dx_d = dx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign dx   = dx_q;
  assign dy   = dy_q;
  assign last = (dx_q == X_MAX) && (dy_q == Y_MAX);

endmodule

// File: rtl/hud_draw.sv
// hud_draw: HUD sprite source for draw_mux (same contract as ball/brick draw).
// On an accepted go it latches lives and min(health_left, BAR_W), then emits
// one pixel per clock: three 2x2 life pips, then a BAR_W x BAR_H health bar.
//  clk, resetn  : clock, synchronous active-low reset
//  go           : 1-cycle start pulse, accepted only in IDLE
//  lives        : remaining lives 0..3
//  health_left  : remaining total brick health
//  writeEn      : pixel valid; x_out/y_out/colour qualify it
//  busy         : high in LATCH, PIPS, BAR and DONE
//  done         : 1-cycle pulse after the last pixel
// Handshake: writeEn is a plain valid with no back-pressure; draw_fsm grants
// a fixed `HUDDRAW-cycle window. While writeEn=0, x_out/y_out/colour are 0.
// Optional build macro HUD_BLINK_EN: when lives==1, pip 0 blinks, with the
// phase toggling every BLINK_PERIOD accepted gos.
module hud_draw
  import hud_draw_pkg::*;
#(
  parameter int PIP_X0       = DEF_PIP_X0,
  parameter int PIP_Y0       = DEF_PIP_Y0,
  parameter int BAR_X0       = DEF_BAR_X0,
  parameter int BAR_Y0       = DEF_BAR_Y0,
  parameter int BAR_W        = DEF_BAR_W,
  parameter int BAR_H        = DEF_BAR_H,
  parameter int BLINK_PERIOD = DEF_BLINK_PERIOD
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic [1:0] lives,
  input  logic [9:0] health_left,
  output logic       writeEn,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic [2:0] colour,
  output logic       busy,
  output logic       done
);

  // Every pixel must land on the 160x120 screen.
  if (PIP_X0 < 0 || PIP_Y0 < 0 || BAR_X0 < 0 || BAR_Y0 < 0 ||
      BAR_W < 1 || BAR_H < 1 ||
      PIP_X0 + 4 * 2 + 1 > 159 || PIP_Y0 + 1 > 119 ||
      BAR_X0 + BAR_W - 1 > 159 || BAR_Y0 + BAR_H - 1 > 119) begin : g_bounds_err
    $error("hud_draw: HUD geometry leaves the 160x120 screen");
  end
  if (BLINK_PERIOD < 1 || BLINK_PERIOD > 16) begin : g_blink_err
    $error("hud_draw: BLINK_PERIOD must fit the 4-bit blink counter");
  end

  hud_state_e state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [9:0] len_q, len_d;
  logic       pip_fin_q, pip_fin_d;
  logic       bar_fin_q, bar_fin_d;
  logic       we_q, we_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [2:0] col_q, col_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [1:0] pip_dx, pip_dy;
  logic [9:0] bar_dx, bar_dy;
  logic       pip_last, bar_last;
  logic       pip_step, bar_step, scan_clear;
  logic [1:0] lives_eff;
  logic       pip_blank;
  logic       accept;

  assign accept = (state_q == ST_IDLE) && go;

  // The scanners run one cycle ahead of the outputs: their position is the
  // pixel being loaded into the output registers this cycle.
  assign scan_clear = (state_q == ST_IDLE);
  assign pip_step   = (state_d == ST_PIPS);
  assign bar_step   = (state_d == ST_BAR);

  // Pip scan: dx is the pixel within a pip (bit0 = x, bit1 = y), dy the pip.
  hud_scan #(.W(4), .H(3), .CW(2)) u_pip_scan (
    .clk   (clk),
    .resetn(resetn),
    .clear (scan_clear),
    .step  (pip_step),
    .dx    (pip_dx),
    .dy    (pip_dy),
    .last  (pip_last)
  );

  hud_scan #(.W(BAR_W), .H(BAR_H), .CW(10)) u_bar_scan (
    .clk   (clk),
    .resetn(resetn),
    .clear (scan_clear),
    .step  (bar_step),
    .dx    (bar_dx),
    .dy    (bar_dy),
    .last  (bar_last)
  );

  // Pip 0 is loaded during LATCH, before lives_q has been written, so that
  // one cycle takes the value being captured straight from the input.
  assign lives_eff = (state_q == ST_LATCH) ? lives : lives_q;

`ifdef HUD_BLINK_EN
  logic [3:0] blink_cnt_q, blink_cnt_d;
  logic       blink_on_q, blink_on_d;
  logic       blink_lat_q, blink_lat_d;

  // The phase used by a draw is the one in force when its go was accepted.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    blink_lat_d = blink_lat_q;
    if (accept) begin
      blink_lat_d = blink_on_q;
      if (blink_cnt_q == 4'(BLINK_PERIOD - 1)) begin
        blink_cnt_d = 4'd0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      blink_cnt_q <= 4'd0;
      blink_on_q  <= 1'b1;
      blink_lat_q <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      blink_lat_q <= blink_lat_d;
    end
  end

  assign pip_blank = (lives_eff == 2'd1) && !blink_lat_q && (pip_dy == 2'd0);
`else
  assign pip_blank = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    len_d     = len_q;
    pip_fin_d = pip_step && pip_last;
    bar_fin_d = bar_step && bar_last;
    we_d      = 1'b0;
    x_d       = 10'd0;
    y_d       = 10'd0;
    col_d     = COL_BLACK;

    case (state_q)
      ST_IDLE:  if (go) state_d = ST_LATCH;
      ST_LATCH: begin
        lives_d = lives;
        len_d   = clamp_len(health_left, 10'(BAR_W));
        state_d = ST_PIPS;
      end
      // The *_fin flags mark the cycle in which the phase's last pixel is
      // on the outputs, so the state moves on with the outputs.
      ST_PIPS:  if (pip_fin_q) state_d = ST_BAR;
      ST_BAR:   if (bar_fin_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (state_d == ST_PIPS) begin
      we_d  = 1'b1;
      x_d   = 10'(PIP_X0) + {6'd0, pip_dy, 2'b00} + {9'd0, pip_dx[0]};
      y_d   = 10'(PIP_Y0) + {9'd0, pip_dx[1]};
      col_d = ((pip_dy < lives_eff) && !pip_blank) ? COL_RED : COL_BLACK;
    end else if (state_d == ST_BAR) begin
      we_d  = 1'b1;
      x_d   = 10'(BAR_X0) + bar_dx;
      y_d   = 10'(BAR_Y0) + bar_dy;
      col_d = (bar_dx < len_q) ? COL_GREEN : COL_BLACK;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      lives_q   <= 2'd0;
      len_q     <= 10'd0;
      pip_fin_q <= 1'b0;
      bar_fin_q <= 1'b0;
      we_q      <= 1'b0;
      x_q       <= 10'd0;
      y_q       <= 10'd0;
      col_q     <= COL_BLACK;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      len_q     <= len_d;
      pip_fin_q <= pip_fin_d;
      bar_fin_q <= bar_fin_d;
      we_q      <= we_d;
      x_q       <= x_d;
      y_q       <= y_d;
      col_q     <= col_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign writeEn = we_q;
  assign x_out   = x_q;
  assign y_out   = y_q;
  assign colour  = col_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_hud_draw.sv
// tb_hud_draw: directed bench for hud_draw with default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_hud_draw;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       go = 1'b0;
  logic [1:0] lives = 2'd0;
  logic [9:0] health_left = 10'd0;
  logic       writeEn;
  logic [9:0] x_out;
  logic [9:0] y_out;
  logic [2:0] colour;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;
  logic [22:0] exp_q[$];

  hud_draw dut (
    .clk        (clk),
    .resetn     (resetn),
    .go         (go),
    .lives      (lives),
    .health_left(health_left),
    .writeEn    (writeEn),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour     (colour),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    resetn = 1'b0;
    go = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Expected pixel stream {x, y, colour} for one full pass.
  task automatic build_exp(input logic [1:0] l, input logic [9:0] h, input bit blank0);
    int len;
    logic [2:0] c;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      c = ((i < int'(l)) && !(blank0 && i == 0)) ? 3'b100 : 3'b000;
      for (int j = 0; j < 4; j++)
        exp_q.push_back({10'(150 + 4 * i + (j % 2)), 10'(j / 2), c});
    end
    len = (int'(h) > 100) ? 100 : int'(h);
    for (int r = 0; r < 2; r++)
      for (int col = 0; col < 100; col++)
        exp_q.push_back({10'(col), 10'(r), (col < len) ? 3'b010 : 3'b000});
  endtask

  // One go at relative cycle 0; optional extra go at go2_at and input
  // change at chg_at (relative cycles) that must both have no effect.
  task automatic do_pass(input logic [1:0] l, input logic [9:0] h,
                         input int go2_at, input int chg_at,
                         input logic [1:0] l2, input logic [9:0] h2,
                         input bit blank0);
    int first_we = -1;
    int last_we = -1;
    int n_pix = 0;
    int gaps = 0;
    int done_cyc = -1;
    int busy_drop = 0;
    int extra = 0;
    logic [22:0] exp;
    build_exp(l, h, blank0);
    @(negedge clk);
    chk("idle_before_go", {30'd0, busy, writeEn}, 32'd0);
    lives = l;
    health_left = h;
    go = 1'b1;
    for (int c = 1; c <= 260; c++) begin
      @(negedge clk);
      go = (c == go2_at);
      if (c == chg_at) begin
        lives = l2;
        health_left = h2;
      end
      if (c == 1) chk("latch_cycle", {30'd0, busy, writeEn}, 32'd2);
      if (!busy) busy_drop++;
      if (writeEn) begin
        if (first_we < 0) first_we = c;
        if (last_we >= 0 && last_we != c - 1) gaps++;
        last_we = c;
        n_pix++;
        if (exp_q.size() == 0) extra++;
        else begin
          exp = exp_q.pop_front();
          chk("pixel", {9'd0, x_out, y_out, colour}, {9'd0, exp});
        end
      end
      if (done) begin
        done_cyc = c;
        chk("done_no_pixel", {31'd0, writeEn}, 32'd0);
        break;
      end
    end
    chk("first_pixel_cycle", first_we, 32'd2);
    chk("pixel_count", n_pix, 32'd212);
    chk("pixel_gaps", gaps, 32'd0);
    chk("extra_pixels", extra, 32'd0);
    chk("missing_pixels", exp_q.size(), 32'd0);
    chk("done_cycle", done_cyc, 32'd214);
    chk("busy_drop", busy_drop, 32'd0);
    @(negedge clk);
    go = 1'b0;
    chk("idle_after_done", {29'd0, busy, done, writeEn}, 32'd0);
  endtask

  initial begin
    // 1: reset then idle.
    reset_dut();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_outputs", {7'd0, writeEn, busy, done, x_out, y_out, colour}, 32'd0);
    end

    // 2: all pips red, 40 green columns; go in the DONE cycle is ignored.
    do_pass(2'd3, 10'd40, 214, -1, 2'd3, 10'd40, 1'b0);

    // 3: no lives, health beyond the bar width.
    do_pass(2'd0, 10'd500, -1, -1, 2'd0, 10'd500, 1'b0);

    // 4: second go mid-draw and input change mid-draw have no effect.
    do_pass(2'd2, 10'd75, 50, 60, 2'd0, 10'd5, 1'b0);

    // Edge values: health exactly BAR_W and zero health.
    do_pass(2'd1, 10'd100, -1, -1, 2'd1, 10'd100, 1'b0);
    do_pass(2'd2, 10'd0, -1, -1, 2'd2, 10'd0, 1'b0);

    // 5: reset in the middle of the bar.
    @(negedge clk);
    lives = 2'd3;
    health_left = 10'd40;
    go = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      go = 1'b0;
      if (c == 100) begin
        chk("mid_bar_active", {30'd0, busy, writeEn}, 32'd3);
        resetn = 1'b0;
      end
    end
    @(negedge clk);
    chk("reset_mid_bar", {7'd0, writeEn, busy, done, x_out, y_out, colour}, 32'd0);
    resetn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("after_reset_quiet", {29'd0, busy, done, writeEn}, 32'd0);
    end
    do_pass(2'd3, 10'd40, -1, -1, 2'd3, 10'd40, 1'b0);

    // 6: sixteen gos with one life; blink only in the HUD_BLINK_EN build.
    reset_dut();
    for (int k = 1; k <= 16; k++) begin
`ifdef HUD_BLINK_EN
      do_pass(2'd1, 10'd30, -1, -1, 2'd1, 10'd30, (((k - 1) / 8) % 2) == 1);
`else
      do_pass(2'd1, 10'd30, -1, -1, 2'd1, 10'd30, 1'b0);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
